req_pending_counter: RTL and testbench
======================================

REQ_PENDING_COUNTER -- requirements
Module: req_pending_counter

Interface
REQ-001 Parameter WIDTH, default 8: number of request channels; SHALL be 2..32.
REQ-002 Parameter CNT_W, default 4: per-channel pending counter width; SHALL be 1..8.
REQ-003 clk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 flush  input  1  synchronous clear of all counters and flags.
REQ-006 req_pulse  input  WIDTH  single-cycle request events, one bit per channel.
REQ-007 grant_valid  input  1  round-robin encoder output valid (encoder od_valid).
REQ-008 grant_filt  input  WIDTH  one-hot granted channel (encoder od_filt).
REQ-009 pending  output  WIDTH  bit i high when channel i count is nonzero; SHALL drive the encoder id input.
REQ-010 busy  output  1  OR of pending.
REQ-011 cnt_flat  output  WIDTH*CNT_W  channel i count at bits [i*CNT_W +: CNT_W].
REQ-012 ovf  output  WIDTH  sticky per-channel overflow flags (see Configuration).

Function
REQ-013 Per channel: inc = req_pulse[i]; dec = grant_valid & grant_filt[i]. The "next" values below take effect on the following rising edge.
REQ-014 inc & ~dec with count < 2^CNT_W-1: count SHALL become count+1.
REQ-015 inc & ~dec with count = 2^CNT_W-1: count SHALL hold (saturate), and ovf[i] SHALL set.
REQ-016 dec & ~inc with count > 0: count SHALL become count-1.
REQ-017 dec & ~inc with count = 0: count SHALL hold at 0 with no wrap; the spurious grant SHALL be ignored.
REQ-018 inc & dec in the same cycle: count SHALL hold, including at saturation, and ovf SHALL NOT set.
REQ-019 grant_filt with more than one bit set while grant_valid is high: each set bit SHALL be treated as a dec independently; no error is reported.
REQ-020 grant_filt SHALL be ignored while grant_valid is low.
REQ-021 pending, busy and cnt_flat SHALL be combinational decodes of the registered counts; there is no combinational path from any input to any output.
REQ-022 Latency: a req_pulse in cycle N SHALL make pending[i] high in cycle N+1; the grant that takes the count to 0 in cycle N SHALL make pending[i] low in cycle N+1.
REQ-023 flush SHALL override inc and dec: all counts go to 0 and all ovf bits clear in the next cycle.
REQ-024 Channels SHALL be fully independent; there is no cross-channel priority inside this block.

Reset
REQ-025 rst high SHALL immediately force all counts and ovf to 0, so pending=0, busy=0, cnt_flat=0 and ovf=0 regardless of clk.
REQ-026 Deassertion of rst SHALL be safe mid-traffic: events in the first edge after release are counted normally, and events coincident with rst are lost.

Configuration
REQ-027 Macro REQ_PENDING_OVF_EN defined: ovf flags SHALL be implemented per REQ-015/023/025 and stay set until flush or rst.
REQ-028 Macro REQ_PENDING_OVF_EN undefined: ovf SHALL be tied to 0, no flag flops are generated, and saturation behaviour is unchanged.

Structure
REQ-029 Package req_pending_pkg SHALL hold the CNT_W-parameterised count typedef, the saturation-max constant function and the cnt_flat slice helper.
REQ-030 Sub-module req_pending_chan SHALL implement one channel (counter, saturation, flag) and be instantiated WIDTH times via generate; the top level holds only the flattening and busy OR.

Verification
REQ-031 After rst, req_pulse=8'h05 for 1 cycle -> next cycle pending=8'h05, counts of ch0 and ch2 =1, busy=1.
REQ-032 15 pulses on ch3 with CNT_W=4, then 1 more -> count stays 15, ovf[3]=1 when the macro is defined and ovf=0 when it is undefined.
REQ-033 ch1 count=1, req_pulse[1] and grant on ch1 in the same cycle -> count stays 1 and pending[1] stays 1.
REQ-034 grant_valid=1, grant_filt=8'h80 with ch7 count 0 -> count stays 0 with no wrap to 15.
REQ-035 Loopback with round_robin_performance_enc: random pulses on 8 channels for 10000 cycles, then pulses stop -> all counts drain to 0 and the total of grants equals the total of pulses minus the saturated drops.
REQ-036 rst asserted asynchronously mid-burst between edges -> outputs go to 0 before the next edge; flush with simultaneous pulses -> all counts 0 next cycle.

Source files
------------

// File: rtl/req_pending_pkg.sv
// Shared types and helpers for the pending-request counter: count type,
// saturation limit and the position of each channel count in cnt_flat.
package req_pending_pkg;

  localparam int CNT_W_MAX = 8;

  // Wide enough for the largest supported CNT_W; channels keep the low CNT_W bits.
  typedef logic [CNT_W_MAX-1:0] cnt_t;

  function automatic cnt_t sat_max(input int cnt_w);
    return cnt_t'((1 << cnt_w) - 1);
  endfunction

  function automatic int flat_lo(input int idx, input int cnt_w);
    return idx * cnt_w;
  endfunction

endpackage

// File: rtl/req_pending_chan.sv
// One request channel: saturating up/down pending counter with an optional
// sticky overflow flag (built only when REQ_PENDING_OVF_EN is defined).
module req_pending_chan
  import req_pending_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inc,
  input  logic             grant_valid,
  input  logic             grant_bit,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam cnt_t             MAX_FULL = sat_max(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = MAX_FULL[CNT_W-1:0];

  logic             w_dec;
  logic             w_at_max;
  logic             w_at_zero;
  logic [CNT_W-1:0] r_cnt;

  assign w_dec     = grant_valid & grant_bit;
  assign w_at_max  = (r_cnt == CNT_MAX);
  assign w_at_zero = (r_cnt == '0);

  // A simultaneous inc and dec cancels out, even when saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (inc && !w_dec && !w_at_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_dec && !inc && !w_at_zero) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

`ifdef REQ_PENDING_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (flush) begin
      r_ovf <= 1'b0;
    end else if (inc && !w_dec && w_at_max) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/req_pending_counter.sv
// Per-channel pending-request counters feeding a round-robin encoder.
// Optional sticky overflow flags are enabled by defining REQ_PENDING_OVF_EN.
module req_pending_counter
  import req_pending_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       req_pulse,
  input  logic                   grant_valid,
  input  logic [WIDTH-1:0]       grant_filt,
  output logic [WIDTH-1:0]       pending,
  output logic                   busy,
  output logic [WIDTH*CNT_W-1:0] cnt_flat,
  output logic [WIDTH-1:0]       ovf
);

  logic [CNT_W-1:0] w_cnt [WIDTH];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      req_pending_chan #(
        .CNT_W(CNT_W)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .inc        (req_pulse[gi]),
        .grant_valid(grant_valid),
        .grant_bit  (grant_filt[gi]),
        .cnt        (w_cnt[gi]),
        .ovf        (ovf[gi])
      );

      assign cnt_flat[flat_lo(gi, CNT_W) +: CNT_W] = w_cnt[gi];
      assign pending[gi] = |w_cnt[gi];
    end
  endgenerate

  assign busy = |pending;

endmodule

// File: tb/tb_req_pending_counter.sv
// Directed bench for req_pending_counter (WIDTH=8, CNT_W=4) plus a
// round-robin loopback drain check against a small saturating-count model.
module tb_req_pending_counter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
`ifdef REQ_PENDING_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic [WIDTH-1:0]       req_pulse;
  logic                   grant_valid;
  logic [WIDTH-1:0]       grant_filt;
  logic [WIDTH-1:0]       pending;
  logic                   busy;
  logic [WIDTH*CNT_W-1:0] cnt_flat;
  logic [WIDTH-1:0]       ovf;

  int errors = 0;
  int checks = 0;

  req_pending_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_pulse  (req_pulse),
    .grant_valid(grant_valid),
    .grant_filt (grant_filt),
    .pending    (pending),
    .busy       (busy),
    .cnt_flat   (cnt_flat),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return cnt_flat[ch*CNT_W +: CNT_W];
  endfunction

  int                 m_cnt [WIDTH];
  int                 pulses;
  int                 grants;
  int                 drops;
  int                 ptr;
  int                 budget;
  logic [WIDTH-1:0]   pulse_v;
  logic [WIDTH-1:0]   gnt_v;
  logic [31:0]        model_flat;

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    req_pulse   = '0;
    grant_valid = 1'b0;
    grant_filt  = '0;
    tick();

    // Reset state
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cnt_flat", cnt_flat, 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);

    // Pulse on ch0 and ch2
    rst       = 1'b0;
    req_pulse = 8'h05;
    tick();
    req_pulse = 8'h00;
    check("pulse05_pending", 32'(pending), 32'h05);
    check("pulse05_busy", 32'(busy), 32'h1);
    check("pulse05_cnt_flat", cnt_flat, 32'h0000_0101);

    // Saturate ch3: 15 pulses, then one more
    req_pulse = 8'h08;
    for (int i = 0; i < 15; i++) tick();
    check("ch3_at15_cnt", 32'(cnt_of(3)), 32'd15);
    check("ch3_at15_ovf", 32'(ovf), 32'h0);
    tick();
    req_pulse = 8'h00;
    check("ch3_sat_cnt", 32'(cnt_of(3)), 32'd15);
    check("ch3_sat_ovf", 32'(ovf), OVF_ON ? 32'h08 : 32'h0);

    // ch1 to 1, then inc+dec on ch1 and saturated ch3
    req_pulse = 8'h02;
    tick();
    req_pulse   = 8'h0A;
    grant_valid = 1'b1;
    grant_filt  = 8'h0A;
    tick();
    req_pulse   = 8'h00;
    grant_valid = 1'b0;
    grant_filt  = 8'h00;
    check("incdec_ch1_cnt", 32'(cnt_of(1)), 32'd1);
    check("incdec_ch1_pending", 32'(pending[1]), 32'h1);
    check("incdec_ch3_cnt", 32'(cnt_of(3)), 32'd15);
    check("incdec_ovf", 32'(ovf), OVF_ON ? 32'h08 : 32'h0);

    // Spurious grant on empty ch7
    grant_valid = 1'b1;
    grant_filt  = 8'h80;
    tick();
    check("spurious_ch7_cnt", 32'(cnt_of(7)), 32'd0);

    // grant_filt ignored while grant_valid low
    grant_valid = 1'b0;
    grant_filt  = 8'hFF;
    tick();
    check("gv_low_cnt_flat", cnt_flat, 32'h0000_F111);

    // Multi-bit grant decrements each channel
    grant_valid = 1'b1;
    grant_filt  = 8'h0F;
    tick();
    grant_valid = 1'b0;
    grant_filt  = 8'h00;
    check("multi_gnt_cnt_flat", cnt_flat, 32'h0000_E000);
    check("multi_gnt_pending", 32'(pending), 32'h08);

    // Flush beats simultaneous pulses
    flush     = 1'b1;
    req_pulse = 8'hFF;
    tick();
    flush     = 1'b0;
    req_pulse = 8'h00;
    check("flush_cnt_flat", cnt_flat, 32'h0);
    check("flush_ovf", 32'(ovf), 32'h0);
    check("flush_busy", 32'(busy), 32'h0);

    // Async reset mid-burst, then release with traffic running
    req_pulse = 8'hFF;
    tick();
    tick();
    check("burst_cnt_flat", cnt_flat, 32'h2222_2222);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cnt_flat", cnt_flat, 32'h0);
    check("async_rst_pending", 32'(pending), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    tick();
    check("rst_held_cnt_flat", cnt_flat, 32'h0);
    rst = 1'b0;
    tick();
    req_pulse = 8'h00;
    check("rst_release_cnt_flat", cnt_flat, 32'h1111_1111);

    // Round-robin loopback
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < WIDTH; c++) m_cnt[c] = 0;
    pulses = 0;
    grants = 0;
    drops  = 0;
    ptr    = WIDTH - 1;
    for (int cyc = 0; cyc < 10000 + 400; cyc++) begin
      if (cyc >= 10000 && !busy) break;
      gnt_v = '0;
      for (int k = 1; k <= WIDTH; k++) begin
        if (gnt_v == '0 && pending[(ptr + k) % WIDTH]) begin
          gnt_v[(ptr + k) % WIDTH] = 1'b1;
          ptr = (ptr + k) % WIDTH;
        end
      end
      pulse_v = '0;
      if (cyc < 10000) begin
        for (int c = 0; c < WIDTH; c++) pulse_v[c] = ($urandom_range(0, 3) == 0);
      end
      for (int c = 0; c < WIDTH; c++) begin
        if (pulse_v[c]) pulses++;
        if (gnt_v[c]) grants++;
        if (pulse_v[c] && !gnt_v[c]) begin
          if (m_cnt[c] == 15) drops++;
          else m_cnt[c]++;
        end else if (gnt_v[c] && !pulse_v[c] && m_cnt[c] > 0) begin
          m_cnt[c]--;
        end
      end
      req_pulse   = pulse_v;
      grant_valid = |gnt_v;
      grant_filt  = gnt_v;
      tick();
      if (cyc == 9999) begin
        for (int c = 0; c < WIDTH; c++) model_flat[c*CNT_W +: CNT_W] = 4'(m_cnt[c]);
        check("loop_mid_cnt_flat", cnt_flat, model_flat);
      end
    end
    req_pulse   = '0;
    grant_valid = 1'b0;
    grant_filt  = '0;
    check("loop_drained_busy", 32'(busy), 32'h0);
    check("loop_drained_flat", cnt_flat, 32'h0);
    check("loop_grant_total", 32'(grants), 32'(pulses - drops));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
